rr_arb3: RTL and testbench

- Round-robin arbiter that shares one multi-cycle resource between three requesters: a, b and c.
- The resource is one-hot state-machine hardware that can serve only one requester at a time.
- The arbiter sequences ownership: grant, hold until completion, release, then rotate priority.
- It sits between the three request sources and the shared unit. A watchdog reclaims the resource from a stuck owner.

---
 rtl/rr_arb3.sv | 113 +++++++++++
 tb/tb_rr_arb3.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter for a single multi-cycle shared resource.
// Grants are held until done, withdrawal, or watchdog expiry; priority rotates past each owner.
module rr_arb3 #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    req,
  input  logic          done,
  output logic [2:0]    gnt,
  output logic          busy,
  output logic [1:0]    owner,
  output logic          to_pulse,
  output logic [CW-1:0] hold_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    GRANT = 3'b010,
    REL   = 3'b100
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    ptr_reg, ptr_next;
  logic [2:0]    gnt_reg, gnt_next;
  logic [1:0]    owner_reg, owner_next;
  logic          to_pulse_reg, to_pulse_next;
  logic [CW-1:0] hold_cnt_reg, hold_cnt_next;

  // Candidate gi is the requester at priority rank gi, counting from ptr mod 3.
  logic [1:0] cand_idx [3];
  logic [2:0] cand_req;
  logic [1:0] sel_idx;
  logic [1:0] ptr_after_owner;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cand
      logic [2:0] sum;
      assign sum           = {1'b0, ptr_reg} + 3'(gi);
      assign cand_idx[gi]  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      assign cand_req[gi]  = req[cand_idx[gi]];
    end
  endgenerate

  assign sel_idx = cand_req[0] ? cand_idx[0] :
                   cand_req[1] ? cand_idx[1] : cand_idx[2];

  assign ptr_after_owner = (owner_reg == 2'd2) ? 2'd0 : owner_reg + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= 2'd0;
      gnt_reg      <= 3'b000;
      owner_reg    <= 2'd0;
      to_pulse_reg <= 1'b0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      gnt_reg      <= gnt_next;
      owner_reg    <= owner_next;
      to_pulse_reg <= to_pulse_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    gnt_next      = gnt_reg;
    owner_next    = owner_reg;
    to_pulse_next = 1'b0;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next    = GRANT;
          gnt_next      = 3'b001 << sel_idx;
          owner_next    = sel_idx;
          hold_cnt_next = '0;
        end
      end
      GRANT: begin
        // done outranks the watchdog, so a simultaneous completion is not a timeout.
        if (done || !req[owner_reg] || (hold_cnt_reg == CW'(MAX_HOLD - 1))) begin
          state_next    = REL;
          gnt_next      = 3'b000;
          ptr_next      = ptr_after_owner;
          to_pulse_next = !done && req[owner_reg];
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      REL: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 3'b000;
      end
    endcase
  end

  assign gnt      = gnt_reg;
  assign busy     = |gnt_reg;
  assign owner    = owner_reg;
  assign to_pulse = to_pulse_reg;
  assign hold_cnt = hold_cnt_reg;

endmodule

// File: tb/tb_rr_arb3.sv
// Directed, table-driven bench for rr_arb3 with hand-computed expectations.
// Includes hand-written sequences for asynchronous reset and pointer restart.
module tb_rr_arb3;

  localparam int MAX_HOLD = 8;
  localparam int CW       = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req;
  logic          done;
  logic [2:0]    gnt;
  logic          busy;
  logic [1:0]    owner;
  logic          to_pulse;
  logic [CW-1:0] hold_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  rr_arb3 #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .busy     (busy),
    .owner    (owner),
    .to_pulse (to_pulse),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic       done;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic       to;
    logic [3:0] hold;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [2:0] r, input logic d, input logic [2:0] g,
                     input logic [1:0] o, input logic t, input logic [3:0] h);
    vec_t e;
    e.req = r; e.done = d; e.gnt = g; e.owner = o; e.to = t; e.hold = h;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] g, input logic [1:0] o,
                         input logic t, input logic [3:0] h);
    chk({tag, " gnt"}, 32'(gnt), 32'(g));
    chk({tag, " busy"}, 32'(busy), 32'(|g));
    chk({tag, " owner"}, 32'(owner), 32'(o));
    chk({tag, " to_pulse"}, 32'(to_pulse), 32'(t));
    chk({tag, " hold_cnt"}, 32'(hold_cnt), 32'(h));
  endtask

  initial begin
    logic [1:0] o;
    rst  = 1'b1;
    req  = 3'b000;
    done = 1'b0;
    #2;
    chk_all("reset_async", 3'b000, 2'd0, 1'b0, 4'd0);
    step;
    step;
    chk_all("reset_held", 3'b000, 2'd0, 1'b0, 4'd0);
    rst = 1'b0;

    // Single requester a, done on the third grant cycle.
    add(3'b001, 1'b0, 3'b001, 2'd0, 1'b0, 4'd0);
    add(3'b001, 1'b0, 3'b001, 2'd0, 1'b0, 4'd1);
    add(3'b001, 1'b0, 3'b001, 2'd0, 1'b0, 4'd2);
    add(3'b001, 1'b1, 3'b000, 2'd0, 1'b0, 4'd2);
    add(3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 4'd2);
    // All three requesting: b, c, a; done during REL must be ignored.
    for (int k = 0; k < 3; k++) begin
      o = (k == 0) ? 2'd1 : (k == 1) ? 2'd2 : 2'd0;
      add(3'b111, 1'b0, 3'b001 << o, o, 1'b0, 4'd0);
      add(3'b111, 1'b0, 3'b001 << o, o, 1'b0, 4'd1);
      add(3'b111, 1'b0, 3'b001 << o, o, 1'b0, 4'd2);
      add(3'b111, 1'b1, 3'b000, o, 1'b0, 4'd2);
      add((k == 2) ? 3'b000 : 3'b111, 1'b1, 3'b000, o, 1'b0, 4'd2);
    end
    // Watchdog on b, then regrant; second grant ends with done on the watchdog edge.
    add(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 4'd0);
    for (int h = 1; h < 8; h++) add(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 4'(h));
    add(3'b010, 1'b0, 3'b000, 2'd1, 1'b1, 4'd7);
    add(3'b010, 1'b0, 3'b000, 2'd1, 1'b0, 4'd7);
    add(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 4'd0);
    for (int h = 1; h < 8; h++) add(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 4'(h));
    add(3'b010, 1'b1, 3'b000, 2'd1, 1'b0, 4'd7);
    add(3'b000, 1'b0, 3'b000, 2'd1, 1'b0, 4'd7);
    // c granted (ptr=2), withdraws; ptr=0 then prefers a over b.
    add(3'b101, 1'b0, 3'b100, 2'd2, 1'b0, 4'd0);
    add(3'b101, 1'b0, 3'b100, 2'd2, 1'b0, 4'd1);
    add(3'b101, 1'b0, 3'b100, 2'd2, 1'b0, 4'd2);
    add(3'b011, 1'b0, 3'b000, 2'd2, 1'b0, 4'd2);
    add(3'b011, 1'b0, 3'b000, 2'd2, 1'b0, 4'd2);
    add(3'b011, 1'b0, 3'b001, 2'd0, 1'b0, 4'd0);
    add(3'b011, 1'b0, 3'b001, 2'd0, 1'b0, 4'd1);

    foreach (tbl[i]) begin
      req  = tbl[i].req;
      done = tbl[i].done;
      step;
      $display("row %0d req=%b done=%b -> gnt=%b busy=%b owner=%0d to=%b hold=%0d",
               i, tbl[i].req, tbl[i].done, gnt, busy, owner, to_pulse, hold_cnt);
      chk_all($sformatf("row%0d", i), tbl[i].gnt, tbl[i].owner, tbl[i].to, tbl[i].hold);
    end

    // Asynchronous reset mid-grant, between clock edges.
    #3;
    rst = 1'b1;
    #1;
    $display("async reset mid-grant -> gnt=%b busy=%b hold=%0d", gnt, busy, hold_cnt);
    chk_all("rst_mid_grant", 3'b000, 2'd0, 1'b0, 4'd0);
    step;
    rst  = 1'b0;
    req  = 3'b100;
    done = 1'b0;
    step;
    $display("after reset req=100 -> gnt=%b owner=%0d", gnt, owner);
    chk_all("post_rst_c", 3'b100, 2'd2, 1'b0, 4'd0);
    done = 1'b1;
    step;
    done = 1'b0;
    req  = 3'b111;
    step;
    step;
    $display("req=111 ptr=0 -> gnt=%b", gnt);
    chk_all("ptr0_grant_a", 3'b001, 2'd0, 1'b0, 4'd0);
    done = 1'b1;
    step;
    done = 1'b0;
    // ptr is now 1; reset must restart it at 0 so a wins again.
    #3;
    rst = 1'b1;
    #1;
    chk_all("rst_in_idle", 3'b000, 2'd0, 1'b0, 4'd0);
    step;
    rst = 1'b0;
    step;
    $display("after reset req=111 -> gnt=%b owner=%0d", gnt, owner);
    chk_all("ptr_restart", 3'b001, 2'd0, 1'b0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
